// File: rtl/eth_pkg.sv
// Shared Ethernet receive constants, frame-length defaults and receive FSM states.
// Latency: not applicable (declarations only).
// Backpressure: not applicable (declarations only).
`timescale 1ns/1ps
package eth_pkg;

   // CRC-32 as used for the Ethernet FCS (MSB-first form of the polynomial)
   localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
   localparam logic [31:0] CRC32_SEED    = 32'hFFFFFFFF;
   // Register value left after folding a frame plus its own correct FCS
   localparam logic [31:0] CRC32_RESIDUE = 32'hC704DD7B;

   // Legal frame length, DA through FCS, in bytes
   localparam int MIN_FRAME_DEF = 64;
   localparam int MAX_FRAME_DEF = 1518;

   // Preamble/SFD pattern recognised by the upstream detector
   localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
   localparam logic [7:0] SFD_BYTE      = 8'hD5;
   localparam int         PREAMBLE_LEN  = 7;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RECEIVE = 2'd1,
      ST_DRAIN   = 2'd2
   } rx_state_e;

endpackage

// File: rtl/crc32_d8.sv
// Combinational CRC-32 next state for one byte, data bits folded LSB first.
// Latency: 0 cycles, pure combinational.
// Backpressure: none; the caller decides when to register the result.
`timescale 1ns/1ps
module crc32_d8
   import eth_pkg::*;
(
   input  logic [31:0] crc_in,
   input  logic [7:0]  data,
   output logic [31:0] crc_out
);

   logic [31:0] c;

   // Eight serial LFSR steps unrolled; bit 0 of the byte goes first on the wire
   always_comb begin
      c = crc_in;
      for (int i = 0; i < 8; i++) begin
         if (c[31] ^ data[i]) begin
            c = {c[30:0], 1'b0} ^ CRC32_POLY;
         end else begin
            c = {c[30:0], 1'b0};
         end
      end
      crc_out = c;
   end

endmodule

// File: rtl/mac_rx_frame.sv
// GMII receive framer: strips FCS, checks CRC/length, streams bytes with tlast/tuser (MAC_RX_STATS_EN adds frame counters).
// Latency: 6 cycles from rxd sample to m_axis beat (input reg, 4-byte FCS window, hold reg, output reg).
// Backpressure: none; the stream cannot stall, bytes are emitted at line rate.
`timescale 1ns/1ps
module mac_rx_frame
   import eth_pkg::*;
#(
   parameter int MIN_FRAME = MIN_FRAME_DEF,
   parameter int MAX_FRAME = MAX_FRAME_DEF
)
(
   input  logic       mac_gmii_rx_clk,
   input  logic       mac_gmii_rx_rstn,
   input  logic [7:0] mac_gmii_rxd,
   input  logic       mac_gmii_rx_dv,
   input  logic       mac_gmii_rx_er,
   input  logic       preamble_sfd_valid,
   output logic [7:0] m_axis_tdata,
   output logic       m_axis_tvalid,
   output logic       m_axis_tlast,
   output logic       m_axis_tuser,
   output logic       last_byte_sent,
   output logic       error
`ifdef MAC_RX_STATS_EN
   ,
   output logic [31:0] rx_good_cnt,
   output logic [31:0] rx_bad_cnt
`endif
);

   localparam int                LEN_W   = $clog2(MAX_FRAME + 2);
   localparam logic [LEN_W-1:0]  LEN_SAT = LEN_W'(MAX_FRAME + 1);
   localparam logic [LEN_W-1:0]  LEN_MIN = LEN_W'(MIN_FRAME);
   localparam logic [LEN_W-1:0]  LEN_MAX = LEN_W'(MAX_FRAME);
   localparam logic [LEN_W-1:0]  WIN_LEN = LEN_W'(4);

   rx_state_e        state_q, state_d;

   logic [7:0]       in_dat;
   logic             in_dv, in_er, in_sfd;
   logic             data_valid;
   logic             start, accept, eof, abort;
   logic             frame_bad;

   logic [3:0][7:0]  win_q;
   logic [7:0]       hold_q;
   logic             hold_vld;
   logic [31:0]      crc_q, crc_base, crc_next;
   logic [LEN_W-1:0] len_q;

   // Register the GMII inputs once so all framing decisions use clean flops
   always_ff @(posedge mac_gmii_rx_clk or negedge mac_gmii_rx_rstn) begin
      if (!mac_gmii_rx_rstn) begin
         in_dat <= '0;
         in_dv  <= 1'b0;
         in_er  <= 1'b0;
         in_sfd <= 1'b0;
      end else begin
         in_dat <= mac_gmii_rxd;
         in_dv  <= mac_gmii_rx_dv;
         in_er  <= mac_gmii_rx_er;
         in_sfd <= preamble_sfd_valid;
      end
   end

   assign data_valid = in_dv & ~in_er;

   // State register
   always_ff @(posedge mac_gmii_rx_clk or negedge mac_gmii_rx_rstn) begin
      if (!mac_gmii_rx_rstn) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and per-cycle datapath commands
   always_comb begin
      state_d = state_q;
      start   = 1'b0;
      accept  = 1'b0;
      eof     = 1'b0;
      abort   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (in_sfd && data_valid) begin
               start   = 1'b1;
               state_d = ST_RECEIVE;
            end
         end
         ST_RECEIVE: begin
            if (!in_dv) begin
               eof     = 1'b1;
               state_d = ST_IDLE;
            end else if (in_er) begin
               abort   = 1'b1;
               state_d = ST_DRAIN;
            end else begin
               accept  = 1'b1;
            end
         end
         ST_DRAIN: begin
            if (!in_dv) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // The first byte of a frame folds into the seed rather than the stale register
   assign crc_base = start ? CRC32_SEED : crc_q;

   crc32_d8 u_crc (
      .crc_in  (crc_base),
      .data    (in_dat),
      .crc_out (crc_next)
   );

   assign frame_bad = (crc_q != CRC32_RESIDUE) || (len_q < LEN_MIN) || (len_q > LEN_MAX);

   // FCS window, hold register, CRC/length tracking and registered stream outputs
   always_ff @(posedge mac_gmii_rx_clk or negedge mac_gmii_rx_rstn) begin
      if (!mac_gmii_rx_rstn) begin
         win_q          <= '0;
         hold_q         <= '0;
         hold_vld       <= 1'b0;
         crc_q          <= '0;
         len_q          <= '0;
         m_axis_tdata   <= '0;
         m_axis_tvalid  <= 1'b0;
         m_axis_tlast   <= 1'b0;
         m_axis_tuser   <= 1'b0;
         last_byte_sent <= 1'b0;
         error          <= 1'b0;
      end else begin
         m_axis_tvalid  <= 1'b0;
         m_axis_tlast   <= 1'b0;
         m_axis_tuser   <= 1'b0;
         last_byte_sent <= 1'b0;
         error          <= 1'b0;
         if (start) begin
            crc_q    <= crc_next;
            len_q    <= LEN_W'(1);
            win_q    <= {24'h0, in_dat};
            hold_vld <= 1'b0;
         end else if (accept) begin
            crc_q <= crc_next;
            win_q <= {win_q[2:0], in_dat};
            if (len_q != LEN_SAT) begin
               len_q <= len_q + 1'b1;
            end
            // Once four bytes are buffered, the oldest one can no longer be FCS
            if (len_q >= WIN_LEN) begin
               hold_q   <= win_q[3];
               hold_vld <= 1'b1;
               if (hold_vld) begin
                  m_axis_tdata  <= hold_q;
                  m_axis_tvalid <= 1'b1;
               end
            end
         end else if (eof || abort) begin
            // Hold byte is the last payload byte; the window holds the FCS and is dropped
            hold_vld <= 1'b0;
            if (hold_vld) begin
               m_axis_tdata   <= hold_q;
               m_axis_tvalid  <= 1'b1;
               m_axis_tlast   <= 1'b1;
               m_axis_tuser   <= abort | frame_bad;
               last_byte_sent <= 1'b1;
            end
            error <= abort | frame_bad;
         end
      end
   end

`ifdef MAC_RX_STATS_EN
   // Good/bad frame counters, free-running and wrapping
   always_ff @(posedge mac_gmii_rx_clk or negedge mac_gmii_rx_rstn) begin
      if (!mac_gmii_rx_rstn) begin
         rx_good_cnt <= '0;
         rx_bad_cnt  <= '0;
      end else if (eof && !frame_bad) begin
         rx_good_cnt <= rx_good_cnt + 32'd1;
      end else if (eof || abort) begin
         rx_bad_cnt  <= rx_bad_cnt + 32'd1;
      end
   end
`endif

endmodule
